sync_event_arbiter: RTL
=======================

// Module: sync_event_arbiter
// PURPOSE
//  Collects edge events from NUM_IN asynchronous inputs (GPIO pins, external IRQ lines) and serialises them
//  onto a single valid/ready event port for the CPU interrupt/event unit.
//  Each input is synchronised by an instance of the existing `synchronizer` block, edge-detected,
//  latched as pending, and granted round-robin.
// PARAMETERS
//  NUM_IN    8  number of asynchronous inputs (2..32)
//  FF_COUNT  3  synchronizer depth passed to every synchronizer instance
//  ID_W      $clog2(NUM_IN)  derived localparam, width of evt_id
// PORTS
//  clk         in   1       system clock; single clock domain
//  reset       in   1       synchronous, active-high reset
//  in_async    in   NUM_IN  asynchronous inputs
//  rise_en     in   NUM_IN  per-input rising-edge enable (quasi-static)
//  fall_en     in   NUM_IN  per-input falling-edge enable (quasi-static)
//  evt_valid   out  1       event offered
//  evt_ready   in   1       consumer accepts event
//  evt_id      out  ID_W    index of the offered input
//  evt_rising  out  1       1 = rising edge, 0 = falling edge
//  pending     out  NUM_IN  latched, not yet delivered events
//  overflow    out  NUM_IN  1-cycle pulse: enabled edge hit an already-pending input
// BEHAVIOUR
//  - Reset: evt_valid=0, evt_id=0, evt_rising=0, pending=0, overflow=0, RR pointer=0, FSM=IDLE.
//    Arm counter is cleared; edge registers are cleared.
//  - Synchronizer instances get .resetn(~reset). Their output lags in_async by FF_COUNT+1 clk edges.
//  - Arming: for FF_COUNT+2 cycles after reset deasserts, edge detection is off.
//    During arming, prev[i] tracks sync[i]. A pin already high at reset therefore raises no event.
//  - Edge detection: rise = sync & ~prev, fall = ~sync & prev; prev <= sync every cycle.
//    An edge is enabled when (rise & rise_en) | (fall & fall_en).
//  - An enabled edge on a non-pending input sets pending[i] and stores the direction in dir[i].
//  - An enabled edge on a pending input pulses overflow[i] for 1 cycle.
//    dir[i] is overwritten with the newest direction and pending stays 1.
//  - Clearing rise_en/fall_en does not clear existing pending bits.
//  - FSM IDLE:
//    if |pending, select the first pending index at or above ptr, wrapping modulo NUM_IN.
//    Register evt_id=sel and evt_rising=dir[sel], set evt_valid=1, go to OFFER.
//  - FSM OFFER:
//    evt_valid, evt_id and evt_rising hold stable until handshake.
//    On evt_valid & evt_ready: clear pending[evt_id], ptr <= (evt_id+1) mod NUM_IN, evt_valid=0, go to IDLE.
//  - Handshake plus a new enabled edge on the same input in the same cycle:
//    pending[evt_id] stays 1, dir is updated, no overflow pulse.
//  - Edges on other inputs during OFFER are latched normally.
//  - Throughput: at most 1 event per 2 cycles. evt_ready may be held high permanently.
//  - Latency: in_async change sampled at edge 1 -> pending at edge FF_COUNT+2 -> evt_valid high after
//    edge FF_COUNT+3 (6 cycles at FF_COUNT=3), given an idle FSM.
//  - Reset mid-OFFER: evt_valid drops the next cycle, the event is lost, and re-arming restarts.
//  - Pointer wrap: after granting NUM_IN-1, the search starts at 0.
// STRUCTURE
//  - Package sync_event_pkg: typedef enum logic {IDLE, OFFER} sea_state_t; function clog2-safe ID width.
//  - Sub-modules:
//    NUM_IN generate-loop instances of synchronizer;
//    one combinational sub-module rr_picker #(N) (req, ptr -> gnt_valid, gnt_idx).
//  - Top level holds the arm counter, prev/pending/dir registers and the 2-state FSM.
// TESTING
//  1. Pin 2 high during and after reset, rise_en=all -> no event ever.
//     Pin 2 toggles 1->0 with fall_en[2]=1 -> evt_id=2, evt_rising=0.
//  2. Pin 3 rises, evt_ready=1 -> evt_valid high 6 cycles after the in_async change; pending[3] clears on handshake.
//  3. Pins 1, 5, 6 rise in the same cycle, evt_ready=1 -> grants in order 1, 5, 6, one every 2 cycles.
//     A further rise on pin 1 is then granted after pin 6 (RR).
//  4. Pin 4 rises, then falls while pending, evt_ready=0 -> overflow[4] pulses 1 cycle.
//     On ready the event delivers evt_rising=0.
//  5. Pin 0 toggles in the handshake cycle of its own event -> no overflow; pending[0] stays 1; a second event follows.
//  6. Reset asserted in OFFER with evt_ready=0 -> evt_valid=0 and pending=0 next cycle;
//     no events during the 5 arming cycles.

Source files
------------

// File: rtl/sync_event_pkg.sv
// Shared types and helpers for the synchronised edge-event arbiter.
package sync_event_pkg;

  typedef enum logic {IDLE, OFFER} sea_state_t;

  // Index width that stays at least 1 bit for tiny input counts.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_picker
  import sync_event_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (W + 1)'(k);
      if (cand >= (W + 1)'(N)) cand = cand - (W + 1)'(N);
      if (req[cand[W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchroniser: an input capture flop followed by FF_COUNT resolution stages,
// so q lags d by FF_COUNT+1 clock edges.
module synchronizer #(
  parameter int FF_COUNT = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [FF_COUNT:0] chain;

  always_ff @(posedge clk) begin
    if (!resetn) chain <= '0;
    else         chain <= {chain[FF_COUNT-1:0], d};
  end

  assign q = chain[FF_COUNT];

endmodule

// File: rtl/sync_event_arbiter.sv
// Synchronises NUM_IN async pins, latches enabled edges as pending events and
// serialises them round-robin onto one valid/ready event port.
module sync_event_arbiter
  import sync_event_pkg::*;
#(
  parameter  int NUM_IN   = 8,
  parameter  int FF_COUNT = 3,
  localparam int ID_W     = id_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_async,
  input  logic [NUM_IN-1:0] rise_en,
  input  logic [NUM_IN-1:0] fall_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic              evt_rising,
  output logic [NUM_IN-1:0] pending,
  output logic [NUM_IN-1:0] overflow
);

  localparam int ARM_CYC = FF_COUNT + 2;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);

  logic [NUM_IN-1:0] sync, prev, dir;
  logic [NUM_IN-1:0] rise, fall, hit, take;
  logic [ARM_W-1:0]  arm_cnt;
  logic              armed, hs;

  sea_state_t        state, state_n;
  logic              valid_n, rising_n;
  logic [ID_W-1:0]   id_n, ptr, ptr_n;
  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_idx;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
    synchronizer #(.FF_COUNT(FF_COUNT)) u_sync (
      .clk    (clk),
      .resetn (~reset),
      .d      (in_async[i]),
      .q      (sync[i])
    );
  end

  // Edge detection stays off until the cleared sync chains have filled with real pin levels.
  assign armed = (arm_cnt == ARM_W'(ARM_CYC));
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
  assign hit   = ((rise & rise_en) | (fall & fall_en)) & {NUM_IN{armed}};
  assign hs    = evt_valid & evt_ready;
  assign take  = hs ? (NUM_IN'(1) << evt_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt  <= '0;
      prev     <= '0;
      pending  <= '0;
      dir      <= '0;
      overflow <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
      prev     <= sync;
      // A fresh edge in the grant cycle re-arms the same input rather than overflowing.
      pending  <= hit | (pending & ~take);
      dir      <= (dir & ~hit) | (rise & hit);
      overflow <= hit & pending & ~take;
    end
  end

  rr_picker #(.N(NUM_IN)) u_pick (
    .req       (pending),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_rising <= 1'b0;
      ptr        <= '0;
    end else begin
      state      <= state_n;
      evt_valid  <= valid_n;
      evt_id     <= id_n;
      evt_rising <= rising_n;
      ptr        <= ptr_n;
    end
  end

  always_comb begin
    state_n  = state;
    valid_n  = evt_valid;
    id_n     = evt_id;
    rising_n = evt_rising;
    ptr_n    = ptr;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          valid_n  = 1'b1;
          id_n     = gnt_idx;
          rising_n = dir[gnt_idx];
          state_n  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_n = 1'b0;
          ptr_n   = (evt_id == ID_W'(NUM_IN - 1)) ? '0 : evt_id + ID_W'(1);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
